kernel_launcher: RTL and testbench

Host-facing kernel launch queue that sequences the GPU's single block dispatch unit. Buffers up to QUEUE_DEPTH pending kernel launches, each a thread count plus tag. Runs them one at a time: reset dispatch, hold start until dispatch signals done, report completion. Sits between the device control interface and dispatch, replacing direct host drive of dispatch start/reset/thread_count.

---
 rtl/gpu_launch_pkg.sv | 22 ++
 rtl/launch_fifo.sv | 57 +++++
 rtl/kernel_launcher.sv | 141 ++++++++++++++
 tb/tb_kernel_launcher.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_launch_pkg.sv
// gpu_launch_pkg: shared launch-queue types for kernel_launcher and launch_fifo
//   launch_state_t  : launcher FSM states
//   launch_entry_t  : one pending launch (thread count + tag), default tag width
//   THREAD_COUNT_WIDTH : width of the dispatch thread count
package gpu_launch_pkg;

    localparam int THREAD_COUNT_WIDTH = 8;
    localparam int DEFAULT_ID_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        RESET,
        RUN,
        COMPLETE
    } launch_state_t;

    typedef struct packed {
        logic [THREAD_COUNT_WIDTH-1:0] thread_count;
        logic [DEFAULT_ID_WIDTH-1:0]   id;
    } launch_entry_t;

endpackage

// File: rtl/launch_fifo.sv
// launch_fifo: synchronous FIFO of pending kernel launches
//   clk, reset        : clock, synchronous active-high reset (empties the queue)
//   push, push_data   : write one entry at the tail (ignored when full)
//   pop, head         : head is the oldest entry; pop retires it (ignored when empty)
//   full, empty, count: occupancy, count is registered
// Depth must be a power of two so the pointers wrap by plain overflow.
module launch_fifo
    import gpu_launch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter type entry_t = launch_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    output entry_t                 head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    entry_t mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic do_push;
    logic do_pop;

    assign full    = count == (PW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + PW'(1);
            count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/kernel_launcher.sv
// kernel_launcher: host-facing launch queue sequencing the single block dispatch unit
//   clk, reset                 : clock, synchronous active-high reset
//   enq_valid/ready, enq_*     : host pushes {thread_count, id}; ready = queue not full
//   dispatch_reset/start/thread_count, dispatch_done : drive and observe dispatch
//   kernel_done/_id/_error     : one-cycle completion report per kernel
//   busy, queue_count, kernels_completed : status
// Optional LAUNCH_TIMEOUT_EN: watchdog aborts a RUN after TIMEOUT_CYCLES cycles
// and reports it with kernel_error; without it RUN waits for dispatch_done forever.
module kernel_launcher
    import gpu_launch_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int ID_WIDTH       = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [7:0]                   enq_thread_count,
    input  logic [ID_WIDTH-1:0]          enq_id,
    output logic                         dispatch_reset,
    output logic                         dispatch_start,
    output logic [7:0]                   dispatch_thread_count,
    input  logic                         dispatch_done,
    output logic                         kernel_done,
    output logic [ID_WIDTH-1:0]          kernel_done_id,
    output logic                         kernel_error,
    output logic                         busy,
    output logic [$clog2(QUEUE_DEPTH):0] queue_count,
    output logic [15:0]                  kernels_completed
);

    typedef struct packed {
        logic [THREAD_COUNT_WIDTH-1:0] thread_count;
        logic [ID_WIDTH-1:0]           id;
    } entry_t;

    launch_state_t state;
    entry_t head;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic [ID_WIDTH-1:0] cur_id;
    logic [THREAD_COUNT_WIDTH-1:0] cur_thread_count;

`ifdef LAUNCH_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] run_cycles;
`endif

    assign enq_ready = !full;
    assign push      = enq_valid && enq_ready;
    assign pop       = (state == IDLE) && !empty;

    launch_fifo #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ('{thread_count: enq_thread_count, id: enq_id}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (queue_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= IDLE;
            dispatch_reset        <= 1'b1;
            dispatch_start        <= 1'b0;
            dispatch_thread_count <= '0;
            kernel_done           <= 1'b0;
            kernel_done_id        <= '0;
            kernel_error          <= 1'b0;
            busy                  <= 1'b0;
            kernels_completed     <= '0;
            cur_id                <= '0;
            cur_thread_count      <= '0;
`ifdef LAUNCH_TIMEOUT_EN
            run_cycles            <= '0;
`endif
        end else begin
            dispatch_reset <= 1'b0;
            kernel_done    <= 1'b0;
            kernel_error   <= 1'b0;
            // Idle next cycle only if nothing is in flight and the queue stays empty.
            busy <= (state == RESET) || (state == RUN) || !empty || push;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_id           <= head.id;
                        cur_thread_count <= head.thread_count;
                        if (head.thread_count != '0) begin
                            state          <= RESET;
                            dispatch_reset <= 1'b1;
                        end else begin
                            // Empty kernel: report it without touching dispatch.
                            state             <= COMPLETE;
                            kernel_done       <= 1'b1;
                            kernel_done_id    <= head.id;
                            kernels_completed <= kernels_completed + 16'd1;
                        end
                    end
                end
                RESET: begin
                    state                 <= RUN;
                    dispatch_start        <= 1'b1;
                    dispatch_thread_count <= cur_thread_count;
`ifdef LAUNCH_TIMEOUT_EN
                    run_cycles            <= '0;
`endif
                end
                RUN: begin
`ifdef LAUNCH_TIMEOUT_EN
                    run_cycles <= run_cycles + 16'd1;
                    if (dispatch_done || run_cycles == TIMEOUT_LAST) begin
                        // A done arriving with the timeout still counts as success.
                        kernel_error <= !dispatch_done;
`else
                    if (dispatch_done) begin
`endif
                        state             <= COMPLETE;
                        dispatch_start    <= 1'b0;
                        kernel_done       <= 1'b1;
                        kernel_done_id    <= cur_id;
                        kernels_completed <= kernels_completed + 16'd1;
                    end
                end
                COMPLETE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kernel_launcher.sv
// tb_kernel_launcher: directed + random checks of kernel_launcher against a queue model
module tb_kernel_launcher;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enq_valid = 1'b0;
    logic       enq_ready;
    logic [7:0] enq_thread_count = '0;
    logic [3:0] enq_id = '0;
    logic       dispatch_reset;
    logic       dispatch_start;
    logic [7:0] dispatch_thread_count;
    logic       dispatch_done = 1'b0;
    logic       kernel_done;
    logic [3:0] kernel_done_id;
    logic       kernel_error;
    logic       busy;
    logic [2:0] queue_count;
    logic [15:0] kernels_completed;

    int n_checks = 0;
    int n_fail = 0;

    kernel_launcher #(
        .QUEUE_DEPTH    (4),
        .ID_WIDTH       (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .enq_valid             (enq_valid),
        .enq_ready             (enq_ready),
        .enq_thread_count      (enq_thread_count),
        .enq_id                (enq_id),
        .dispatch_reset        (dispatch_reset),
        .dispatch_start        (dispatch_start),
        .dispatch_thread_count (dispatch_thread_count),
        .dispatch_done         (dispatch_done),
        .kernel_done           (kernel_done),
        .kernel_done_id        (kernel_done_id),
        .kernel_error          (kernel_error),
        .busy                  (busy),
        .queue_count           (queue_count),
        .kernels_completed     (kernels_completed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Dispatch unit model: done is sticky until dispatch_reset, raised after
    // the configured number of cycles with start high.
    int  done_delay = 20;
    int  rand_delay = 5;
    bit  rand_mode = 1'b0;
    bit  never_done = 1'b0;
    int  run_cnt = 0;

    always @(posedge clk) begin
        if (dispatch_reset) begin
            dispatch_done <= 1'b0;
            run_cnt       <= 0;
            rand_delay    <= $urandom_range(1, 12);
        end else if (dispatch_start && !never_done) begin
            run_cnt <= run_cnt + 1;
            if (run_cnt + 1 >= (rand_mode ? rand_delay : done_delay))
                dispatch_done <= 1'b1;
        end
    end

    // Launch model: accepted launches complete strictly in order.
    typedef struct {
        int tc;
        int id;
        bit err;
    } exp_t;

    exp_t q[$];
    int   done_log[$];
    int   comp_model = 0;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            comp_model = 0;
        end else begin
            if (dispatch_start) begin
                check("start_has_kernel", q.size() > 0, 1);
                if (q.size() > 0) begin
                    check("start_thread_count", dispatch_thread_count, q[0].tc);
                    check("start_nonzero_kernel", q[0].tc != 0, 1);
                end
            end
            if (kernel_done) begin
                check("done_has_kernel", q.size() > 0, 1);
                if (q.size() > 0) begin
                    exp_t e;
                    e = q.pop_front();
                    comp_model++;
                    check("done_id", kernel_done_id, e.id);
                    check("done_error", kernel_error, e.err);
                    check("done_counter", kernels_completed, comp_model & 16'hffff);
                end
                done_log.push_back(int'(kernel_done_id));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic enq(input int tc, input int id, input bit err, output int held);
        held = 0;
        enq_valid = 1'b1;
        enq_thread_count = 8'(tc);
        enq_id = 4'(id);
        while (!enq_ready && held < 500) begin
            tick();
            held++;
        end
        check("enq_accept_bound", held < 500, 1);
        if (enq_ready)
            q.push_back('{tc, id, err});
        tick();
        enq_valid = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!dispatch_start && n < 500) begin
            tick();
            n++;
        end
        check("wait_start_bound", n < 500, 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!kernel_done && n < 500) begin
            tick();
            n++;
        end
        check("wait_done_bound", n < 500, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        check("wait_idle_bound", n < 3000, 1);
        tick();
    endtask

    initial begin
        int held;
        int n;
        int drops;
        int seen;
        int exp_order[6];
        exp_order = '{15, 0, 1, 2, 3, 4};

        // Reset values
        tick();
        tick();
        check("rst_dispatch_reset", dispatch_reset, 1);
        check("rst_dispatch_start", dispatch_start, 0);
        check("rst_queue_count", queue_count, 0);
        check("rst_busy", busy, 0);
        check("rst_kernel_done", kernel_done, 0);
        check("rst_completed", kernels_completed, 0);
        check("rst_enq_ready", enq_ready, 1);
        reset = 1'b0;
        tick();
        check("post_rst_dispatch_reset", dispatch_reset, 0);

        // Single kernel: done 20 cycles after start
        done_delay = 20;
        enq(8, 3, 1'b0, held);
        check("single_qcount", queue_count, 1);
        tick();
        check("single_dreset", dispatch_reset, 1);
        check("single_dstart_in_reset", dispatch_start, 0);
        tick();
        check("single_dstart", dispatch_start, 1);
        check("single_tc", dispatch_thread_count, 8);
        n = 0;
        drops = 0;
        while (!kernel_done && n < 200) begin
            tick();
            n++;
            if (!kernel_done && !dispatch_start)
                drops++;
        end
        check("single_latency", n, done_delay + 1);
        check("single_start_held", drops, 0);
        check("single_done_id", kernel_done_id, 3);
        check("single_start_dropped", dispatch_start, 0);
        check("single_completed", kernels_completed, 1);
        tick();
        check("single_done_pulse", kernel_done, 0);
        tick();
        check("single_idle", busy, 0);

        // Fill the queue behind a long-running kernel
        done_delay = 40;
        done_log.delete();
        enq(1, 15, 1'b0, held);
        wait_start();
        for (int i = 0; i < 4; i++)
            enq(5, i, 1'b0, held);
        check("fill_count", queue_count, 4);
        check("fill_ready_low", enq_ready, 0);
        enq(5, 4, 1'b0, held);
        check("fill_fifth_held", held > 0, 1);
        wait_idle();
        check("fill_done_count", done_log.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < done_log.size())
                check("fill_order", done_log[i], exp_order[i]);

        // Zero-thread kernel
        enq(0, 7, 1'b0, held);
        check("zero_qcount", queue_count, 1);
        check("zero_no_dreset_n1", dispatch_reset, 0);
        tick();
        check("zero_done", kernel_done, 1);
        check("zero_id", kernel_done_id, 7);
        check("zero_error", kernel_error, 0);
        check("zero_no_dreset_n2", dispatch_reset, 0);
        check("zero_no_start_n2", dispatch_start, 0);
        tick();
        check("zero_done_pulse", kernel_done, 0);
        check("zero_no_dreset_n3", dispatch_reset, 0);
        check("zero_no_start_n3", dispatch_start, 0);
        check("zero_idle", busy, 0);

        // Stale done carried from the previous kernel must be ignored
        wait_idle();
        done_delay = 5;
        enq(4, 1, 1'b0, held);
        enq(9, 2, 1'b0, held);
        wait_start();
        wait_done(n);
        check("stale_first_id", kernel_done_id, 1);
        tick();
        seen = 0;
        n = 0;
        while (!dispatch_start && n < 50) begin
            if (dispatch_reset && dispatch_done)
                seen = 1;
            tick();
            n++;
        end
        check("stale_done_present", seen, 1);
        wait_done(n);
        check("stale_latency", n, done_delay + 1);
        check("stale_second_id", kernel_done_id, 2);

        // Reset in the middle of RUN with two queued launches
        wait_idle();
        done_delay = 40;
        enq(3, 5, 1'b0, held);
        wait_start();
        enq(3, 6, 1'b0, held);
        enq(3, 8, 1'b0, held);
        check("midrst_queued", queue_count, 2);
        reset = 1'b1;
        tick();
        check("midrst_dreset", dispatch_reset, 1);
        check("midrst_dstart", dispatch_start, 0);
        check("midrst_qcount", queue_count, 0);
        check("midrst_busy", busy, 0);
        check("midrst_kdone", kernel_done, 0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (kernel_done || dispatch_start || dispatch_reset)
                seen++;
        end
        check("midrst_quiet", seen, 0);
        check("midrst_completed", kernels_completed, 0);

`ifdef LAUNCH_TIMEOUT_EN
        // Watchdog abort, then the next kernel runs normally
        done_delay = 20;
        never_done = 1'b1;
        enq(3, 10, 1'b1, held);
        enq(2, 11, 1'b0, held);
        wait_start();
        wait_done(n);
        never_done = 1'b0;
        check("timeout_latency", n, 16);
        check("timeout_error", kernel_error, 1);
        check("timeout_id", kernel_done_id, 10);
        wait_start();
        wait_done(n);
        check("after_timeout_id", kernel_done_id, 11);
        check("after_timeout_error", kernel_error, 0);
        check("after_timeout_latency", n, done_delay + 1);
`endif

        // Random launches with random dispatch latencies
        wait_idle();
        rand_mode = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 2) == 0)
                enq(($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255)),
                    int'($urandom_range(0, 15)), 1'b0, held);
            else
                tick();
        end
        wait_idle();
        check("rand_drained", q.size(), 0);
        check("rand_qcount", queue_count, 0);
        check("rand_counter", kernels_completed, comp_model & 16'hffff);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
